// File: rtl/mem_scheduler_pkg.sv
// Shared types and defaults for the SDRAM request scheduler.
package mem_scheduler_pkg;

   localparam int ADDR_W_DEF         = 22;
   localparam int FREQ_MHZ           = 50;
   // One row refresh every 8 us at the core clock.
   localparam int REFRESH_PERIOD_DEF = FREQ_MHZ * 8;
   localparam int REFRESH_DEFER_DEF  = 64;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD,
      S_WAIT
   } state_e;

   typedef enum logic [2:0] {
      REQ_NONE,
      REQ_LDR,
      REQ_REF,
      REQ_CPU,
      REQ_PPU
   } req_e;

   // Loader > urgent refresh > CPU > PPU > normal refresh.
   function automatic req_e pick_winner(input logic ldr, input logic rf_urgent,
                                        input logic cpu, input logic ppu,
                                        input logic rf_pend);
      if (ldr)       return REQ_LDR;
      if (rf_urgent) return REQ_REF;
      if (cpu)       return REQ_CPU;
      if (ppu)       return REQ_PPU;
      if (rf_pend)   return REQ_REF;
      return REQ_NONE;
   endfunction

endpackage

// File: rtl/mem_scheduler_refresh_timer.sv
// Periodic refresh request generator with a starvation (defer) limit.
module refresh_timer
   import mem_scheduler_pkg::*;
#(
   parameter int REFRESH_PERIOD = REFRESH_PERIOD_DEF,
   parameter int REFRESH_DEFER  = REFRESH_DEFER_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic refresh_taken,
   output logic refresh_pending,
   output logic refresh_urgent,
   output logic overrun
);

   localparam int PW = $clog2(REFRESH_PERIOD);
   localparam int DW = $clog2(REFRESH_DEFER + 1);
   localparam logic [PW-1:0] RELOAD    = PW'(REFRESH_PERIOD - 1);
   localparam logic [DW-1:0] DEFER_MAX = DW'(REFRESH_DEFER);

   logic [PW-1:0] r_period;
   logic [DW-1:0] r_defer;
   logic          r_pending;
   logic          r_overrun;
   logic          w_expire;

   assign w_expire = (r_period == '0);

   // NOTE: non-blocking assignments so every register here updates from pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_period  <= RELOAD;
         r_defer   <= '0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_period  <= w_expire ? RELOAD : r_period - 1'b1;
         r_overrun <= w_expire && r_pending && !refresh_taken;
         // A new expiry re-arms the request even if the old one is taken this cycle.
         if (w_expire)
            r_pending <= 1'b1;
         else if (refresh_taken)
            r_pending <= 1'b0;
         if (refresh_taken || !r_pending)
            r_defer <= '0;
         else if (r_defer != DEFER_MAX)
            r_defer <= r_defer + 1'b1;
      end
   end

   assign refresh_pending = r_pending;
   assign refresh_urgent  = r_pending && (r_defer == DEFER_MAX);
   assign overrun         = r_overrun;

endmodule

// File: rtl/mem_scheduler.sv
// Fixed-priority scheduler sharing one SDRAM controller between CPU, PPU,
// ROM loader and refresh; one command in flight at a time.
module mem_scheduler
   import mem_scheduler_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int REFRESH_PERIOD = REFRESH_PERIOD_DEF,
   parameter int REFRESH_DEFER  = REFRESH_DEFER_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              cpu_valid,
   input  logic              ppu_rd,
   input  logic [ADDR_W-1:0] ppu_addr,
   output logic [7:0]        ppu_dout,
   output logic              ppu_valid,
   input  logic              ldr_wr,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [7:0]        ldr_din,
   output logic              ldr_done,
   output logic              mem_read_a,
   output logic              mem_read_b,
   output logic              mem_write,
   output logic              mem_refresh,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   input  logic              mem_busy,
   input  logic [7:0]        mem_dout_a,
   input  logic [7:0]        mem_dout_b,
   output logic              err
);

   state_e            r_state;
   req_e              r_winner;
   logic              r_win_cpu_rd;

   logic              r_cpu_pend;
   logic              r_cpu_is_wr;
   logic [ADDR_W-1:0] r_cpu_addr;
   logic [7:0]        r_cpu_din;
   logic              r_ppu_pend;
   logic [ADDR_W-1:0] r_ppu_addr;
   logic              r_ldr_pend;
   logic [ADDR_W-1:0] r_ldr_addr;
   logic [7:0]        r_ldr_din;

   logic              w_cpu_req;
   logic              w_req_err;
   logic              w_ref_pend;
   logic              w_ref_urgent;
   logic              w_ref_taken;
   logic              w_overrun;
   req_e              w_winner;

   assign w_cpu_req   = cpu_rd | cpu_wr;
   assign w_req_err   = (cpu_rd & cpu_wr) | (w_cpu_req & r_cpu_pend) |
                        (ppu_rd & r_ppu_pend) | (ldr_wr & r_ldr_pend);
   assign w_ref_taken = (r_state == S_CMD) && (r_winner == REQ_REF);
   assign w_winner    = pick_winner(r_ldr_pend, w_ref_urgent, r_cpu_pend,
                                    r_ppu_pend, w_ref_pend);

   refresh_timer #(
      .REFRESH_PERIOD(REFRESH_PERIOD),
      .REFRESH_DEFER (REFRESH_DEFER)
   ) u_refresh_timer (
      .clk            (clk),
      .resetn         (resetn),
      .refresh_taken  (w_ref_taken),
      .refresh_pending(w_ref_pend),
      .refresh_urgent (w_ref_urgent),
      .overrun        (w_overrun)
   );

   // A pending requester's flag is only cleared by its own CMD cycle, and a
   // repeat request is only accepted once the flag is clear, so the two never collide.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cpu_pend  <= 1'b0;
         r_cpu_is_wr <= 1'b0;
         r_cpu_addr  <= '0;
         r_cpu_din   <= '0;
         r_ppu_pend  <= 1'b0;
         r_ppu_addr  <= '0;
         r_ldr_pend  <= 1'b0;
         r_ldr_addr  <= '0;
         r_ldr_din   <= '0;
         err         <= 1'b0;
      end else begin
         if (r_state == S_CMD && r_winner == REQ_CPU) r_cpu_pend <= 1'b0;
         if (r_state == S_CMD && r_winner == REQ_PPU) r_ppu_pend <= 1'b0;
         if (r_state == S_CMD && r_winner == REQ_LDR) r_ldr_pend <= 1'b0;
         if (w_cpu_req && !r_cpu_pend) begin
            r_cpu_pend  <= 1'b1;
            r_cpu_is_wr <= cpu_wr;
            r_cpu_addr  <= cpu_addr;
            r_cpu_din   <= cpu_din;
         end
         if (ppu_rd && !r_ppu_pend) begin
            r_ppu_pend <= 1'b1;
            r_ppu_addr <= ppu_addr;
         end
         if (ldr_wr && !r_ldr_pend) begin
            r_ldr_pend <= 1'b1;
            r_ldr_addr <= ldr_addr;
            r_ldr_din  <= ldr_din;
         end
         if (w_req_err || w_overrun) err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_winner     <= REQ_NONE;
         r_win_cpu_rd <= 1'b0;
         mem_read_a   <= 1'b0;
         mem_read_b   <= 1'b0;
         mem_write    <= 1'b0;
         mem_refresh  <= 1'b0;
         mem_addr     <= '0;
         mem_din      <= '0;
         cpu_dout     <= '0;
         cpu_valid    <= 1'b0;
         ppu_dout     <= '0;
         ppu_valid    <= 1'b0;
         ldr_done     <= 1'b0;
      end else begin
         // NOTE: strobes and pulses default low every cycle, so each can last only one clock.
         mem_read_a  <= 1'b0;
         mem_read_b  <= 1'b0;
         mem_write   <= 1'b0;
         mem_refresh <= 1'b0;
         cpu_valid   <= 1'b0;
         ppu_valid   <= 1'b0;
         ldr_done    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!mem_busy && w_winner != REQ_NONE) begin
                  r_winner <= w_winner;
                  r_state  <= S_CMD;
                  case (w_winner)
                     REQ_LDR: begin
                        mem_write <= 1'b1;
                        mem_addr  <= r_ldr_addr;
                        mem_din   <= r_ldr_din;
                     end
                     REQ_REF: mem_refresh <= 1'b1;
                     REQ_CPU: begin
                        mem_write    <= r_cpu_is_wr;
                        mem_read_a   <= !r_cpu_is_wr;
                        r_win_cpu_rd <= !r_cpu_is_wr;
                        mem_addr     <= r_cpu_addr;
                        mem_din      <= r_cpu_din;
                     end
                     REQ_PPU: begin
                        mem_read_b <= 1'b1;
                        mem_addr   <= r_ppu_addr;
                     end
                     default: ;
                  endcase
               end
            end
            S_CMD: r_state <= S_WAIT;
            S_WAIT: begin
               if (!mem_busy) begin
                  r_state  <= S_IDLE;
                  r_winner <= REQ_NONE;
                  case (r_winner)
                     REQ_LDR: ldr_done <= 1'b1;
                     REQ_CPU: begin
                        cpu_valid <= 1'b1;
                        if (r_win_cpu_rd) cpu_dout <= mem_dout_a;
                     end
                     REQ_PPU: begin
                        ppu_valid <= 1'b1;
                        ppu_dout  <= mem_dout_b;
                     end
                     default: ;
                  endcase
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed bench for mem_scheduler with a small 4-cycle SDRAM controller model.
module tb_mem_scheduler;

   localparam int AW = 22;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_din = '0;
   logic [7:0]    cpu_dout;
   logic          cpu_valid;
   logic          ppu_rd = 1'b0;
   logic [AW-1:0] ppu_addr = '0;
   logic [7:0]    ppu_dout;
   logic          ppu_valid;
   logic          ldr_wr = 1'b0;
   logic [AW-1:0] ldr_addr = '0;
   logic [7:0]    ldr_din = '0;
   logic          ldr_done;
   logic          mem_read_a, mem_read_b, mem_write, mem_refresh;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          mem_busy;
   logic [7:0]    mem_dout_a = '0, mem_dout_b = '0;
   logic          err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   mem_scheduler dut (
      .clk(clk), .resetn(resetn),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_valid(cpu_valid),
      .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_dout(ppu_dout), .ppu_valid(ppu_valid),
      .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_done(ldr_done),
      .mem_read_a(mem_read_a), .mem_read_b(mem_read_b), .mem_write(mem_write),
      .mem_refresh(mem_refresh), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_busy(mem_busy), .mem_dout_a(mem_dout_a), .mem_dout_b(mem_dout_b),
      .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Controller model: busy rises the cycle after a strobe and stays up three cycles.
   logic       busy_force = 1'b0;
   int         busy_cnt = 0;
   logic [7:0] mem [int];

   assign mem_busy = busy_force || (busy_cnt != 0);

   function automatic logic [7:0] rd_mem(input logic [AW-1:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return a[7:0] ^ 8'hA5;
   endfunction

   always @(posedge clk) begin
      if (mem_read_a | mem_read_b | mem_write | mem_refresh) begin
         busy_cnt <= 3;
         if (mem_write)  mem[int'(mem_addr)] = mem_din;
         if (mem_read_a) mem_dout_a <= rd_mem(mem_addr);
         if (mem_read_b) mem_dout_b <= rd_mem(mem_addr);
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   // Event log: strobes (W/A/B/R) and completions (l/c/p), sampled 2 ns after each edge.
   typedef struct {
      byte           kind;
      logic [AW-1:0] addr;
      logic [7:0]    din;
      int            cyc;
   } ev_t;

   ev_t  evq[$];
   int   proto_errs = 0;
   logic prev_strobe = 1'b0, prev_cv = 1'b0, prev_pv = 1'b0, prev_ld = 1'b0;

   function automatic void push_ev(input byte k);
      ev_t e;
      e.kind = k;
      e.addr = mem_addr;
      e.din  = mem_din;
      e.cyc  = cyc;
      evq.push_back(e);
   endfunction

   always @(posedge clk) begin
      int n;
      #2;
      n = int'(mem_read_a) + int'(mem_read_b) + int'(mem_write) + int'(mem_refresh);
      if (n > 1) proto_errs++;
      if (n != 0 && prev_strobe) proto_errs++;
      if ((cpu_valid && prev_cv) || (ppu_valid && prev_pv) || (ldr_done && prev_ld)) proto_errs++;
      prev_strobe = (n != 0);
      prev_cv = cpu_valid;
      prev_pv = ppu_valid;
      prev_ld = ldr_done;
      if (mem_write)   push_ev("W");
      if (mem_read_a)  push_ev("A");
      if (mem_read_b)  push_ev("B");
      if (mem_refresh) push_ev("R");
      if (ldr_done)    push_ev("l");
      if (cpu_valid)   push_ev("c");
      if (ppu_valid)   push_ev("p");
   end

   function automatic int count_kind(input byte k);
      int n = 0;
      foreach (evq[i]) if (evq[i].kind == k) n++;
      return n;
   endfunction

   function automatic int first_idx(input byte k);
      foreach (evq[i]) if (evq[i].kind == k) return i;
      return -1;
   endfunction

   function automatic string kinds();
      string s = "";
      foreach (evq[i]) s = $sformatf("%s%c", s, evq[i].kind);
      return s;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reset_dut(output int c0);
      resetn = 1'b0;
      busy_force = 1'b0;
      cpu_rd = 1'b0; cpu_wr = 1'b0; ppu_rd = 1'b0; ldr_wr = 1'b0;
      idle(3);
      resetn = 1'b1;
      c0 = cyc;
      evq.delete();
   endtask

   task automatic wait_kind(input byte k, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (count_kind(k) != 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic cpu_read(input logic [AW-1:0] a);
      cpu_rd = 1'b1;
      cpu_addr = a;
      @(negedge clk);
      cpu_rd = 1'b0;
   endtask

   task automatic test_reset;
      bit ok;
      resetn = 1'b0;
      busy_force = 1'b1;
      idle(2);
      checks++;
      if ({mem_read_a, mem_read_b, mem_write, mem_refresh, cpu_valid, ppu_valid,
           ldr_done, err} !== 8'b0 || mem_addr !== '0 || cpu_dout !== 8'h00 || ppu_dout !== 8'h00)
         begin failures++; $display("FAIL reset_outputs: some output nonzero during reset"); end
      resetn = 1'b1;
      evq.delete();
      idle(4);
      cpu_read(22'h000123);
      idle(14);
      checks++;
      if (evq.size() != 0) begin
         failures++; $display("FAIL busy_blocks_issue: got %0d events, expected 0", evq.size());
      end
      busy_force = 1'b0;
      wait_kind("c", 30, ok);
      idle(3);
      checks++;
      if (!ok) begin failures++; $display("FAIL cpu_read_timeout: no cpu_valid within 30 cycles"); end
      checks++;
      if (kinds() != "Ac") begin
         failures++; $display("FAIL cpu_read_seq: got %s expected Ac", kinds());
      end
      checks++;
      if (evq.size() == 0 || evq[0].addr !== 22'h000123) begin
         failures++; $display("FAIL cpu_read_addr: got %0h expected 123",
                              (evq.size() == 0) ? 22'h0 : evq[0].addr);
      end
      checks++;
      if (cpu_dout !== 8'h5A) begin
         failures++; $display("FAIL cpu_read_data: got %0h expected 5a", cpu_dout);
      end
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL err_clean: got %b expected 0", err); end
   endtask

   task automatic test_priority;
      int c0;
      bit ok;
      reset_dut(c0);
      idle(2);
      cpu_rd = 1'b1; cpu_addr = 22'h000111;
      ppu_rd = 1'b1; ppu_addr = 22'h000222;
      ldr_wr = 1'b1; ldr_addr = 22'h200000; ldr_din = 8'hC3;
      @(negedge clk);
      cpu_rd = 1'b0; ppu_rd = 1'b0; ldr_wr = 1'b0;
      wait_kind("p", 60, ok);
      idle(3);
      checks++;
      if (!ok) begin failures++; $display("FAIL prio_timeout: no ppu_valid within 60 cycles"); end
      checks++;
      if (kinds() != "WlAcBp") begin
         failures++; $display("FAIL prio_order: got %s expected WlAcBp", kinds());
      end
      checks++;
      if (evq.size() == 0 || evq[0].addr !== 22'h200000 || evq[0].din !== 8'hC3) begin
         failures++; $display("FAIL ldr_write: got addr %0h din %0h expected 200000 c3",
                              (evq.size() == 0) ? 22'h0 : evq[0].addr,
                              (evq.size() == 0) ? 8'h0 : evq[0].din);
      end
      checks++;
      if (cpu_dout !== 8'h3C) begin
         failures++; $display("FAIL prio_cpu_data: got %0h expected 3c", cpu_dout);
      end
      checks++;
      if (ppu_dout !== 8'h96) begin
         failures++; $display("FAIL prio_ppu_data: got %0h expected 96", ppu_dout);
      end
   endtask

   task automatic test_errors;
      int c0;
      bit ok;
      int ia;
      reset_dut(c0);
      busy_force = 1'b1;
      idle(2);
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL err_initial: got %b expected 0", err); end
      cpu_read(22'h000AAA);
      cpu_read(22'h000BBB);
      idle(1);
      checks++;
      if (err !== 1'b1) begin failures++; $display("FAIL err_dup_cpu: got %b expected 1", err); end
      busy_force = 1'b0;
      wait_kind("c", 40, ok);
      idle(12);
      ia = first_idx("A");
      checks++;
      if (count_kind("A") != 1 || count_kind("c") != 1) begin
         failures++; $display("FAIL dup_single_cmd: got %0d reads %0d valids expected 1 1",
                              count_kind("A"), count_kind("c"));
      end
      checks++;
      if (ia < 0 || evq[ia].addr !== 22'h000AAA) begin
         failures++; $display("FAIL dup_first_addr: got %0h expected aaa",
                              (ia < 0) ? 22'h0 : evq[ia].addr);
      end
      checks++;
      if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", err); end

      reset_dut(c0);
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL err_reset_clear: got %b expected 0", err); end
      cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 22'h000CCC; cpu_din = 8'h77;
      @(negedge clk);
      cpu_rd = 1'b0; cpu_wr = 1'b0;
      idle(1);
      checks++;
      if (err !== 1'b1) begin failures++; $display("FAIL err_rd_wr: got %b expected 1", err); end
      wait_kind("c", 30, ok);
      idle(5);
      checks++;
      if (kinds() != "Wc" || evq[0].addr !== 22'h000CCC || evq[0].din !== 8'h77) begin
         failures++; $display("FAIL rd_wr_write_wins: got %s addr %0h din %0h expected Wc ccc 77",
                              kinds(), (evq.size() == 0) ? 22'h0 : evq[0].addr,
                              (evq.size() == 0) ? 8'h0 : evq[0].din);
      end
      checks++;
      if (err !== 1'b1) begin failures++; $display("FAIL err_sticky2: got %b expected 1", err); end
   endtask

   task automatic test_reset_midop;
      int c0;
      int n0;
      bit ok;
      reset_dut(c0);
      idle(2);
      ppu_rd = 1'b1; ppu_addr = 22'h000222;
      @(negedge clk);
      ppu_rd = 1'b0;
      wait_kind("B", 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL midop_issue: no read_b within 20 cycles"); end
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({mem_read_a, mem_read_b, mem_write, mem_refresh, cpu_valid, ppu_valid,
           ldr_done, err} !== 8'b0 || mem_addr !== '0) begin
         failures++; $display("FAIL midop_async_clear: outputs not cleared immediately");
      end
      n0 = evq.size();
      idle(3);
      resetn = 1'b1;
      idle(20);
      checks++;
      if (evq.size() != n0 || count_kind("p") != 0) begin
         failures++; $display("FAIL midop_no_valid: got %0d new events %0d ppu_valid expected 0 0",
                              evq.size() - n0, count_kind("p"));
      end
      checks++;
      if (ppu_dout !== 8'h00) begin
         failures++; $display("FAIL midop_ppu_dout: got %0h expected 0", ppu_dout);
      end
   endtask

   task automatic test_refresh;
      int c0;
      int ir;
      int rel;
      bit ok;
      reset_dut(c0);
      wait_kind("R", 420, ok);
      idle(8);
      ir = first_idx("R");
      rel = (ir < 0) ? -1 : evq[ir].cyc - c0;
      checks++;
      if (!ok || count_kind("R") != 1) begin
         failures++; $display("FAIL refresh_count: got %0d expected 1", count_kind("R"));
      end
      checks++;
      if (rel < 399 || rel > 403) begin
         failures++; $display("FAIL refresh_time: got cycle %0d expected 401", rel);
      end
      checks++;
      if (count_kind("c") + count_kind("p") + count_kind("l") != 0) begin
         failures++; $display("FAIL refresh_no_valid: got %0d pulses expected 0",
                              count_kind("c") + count_kind("p") + count_kind("l"));
      end
   endtask

   task automatic test_refresh_urgent;
      int c0;
      int ir;
      int rel;
      reset_dut(c0);
      idle(2);
      cpu_addr = 22'h000111;
      ppu_addr = 22'h000222;
      cpu_rd = 1'b1;
      ppu_rd = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 520; i++) begin
         cpu_rd = cpu_valid;
         ppu_rd = ppu_valid;
         @(negedge clk);
      end
      cpu_rd = 1'b0;
      ppu_rd = 1'b0;
      idle(20);
      ir = first_idx("R");
      rel = (ir < 0) ? -1 : evq[ir].cyc - c0;
      checks++;
      if (count_kind("R") != 1) begin
         failures++; $display("FAIL urgent_count: got %0d expected 1", count_kind("R"));
      end
      checks++;
      if (rel < 462 || rel > 480) begin
         failures++; $display("FAIL urgent_time: got cycle %0d expected 465..470", rel);
      end
      checks++;
      if (count_kind("c") < 40 || count_kind("p") < 40) begin
         failures++; $display("FAIL urgent_traffic: got %0d cpu %0d ppu expected >=40 each",
                              count_kind("c"), count_kind("p"));
      end
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL urgent_err: got %b expected 0", err); end
   endtask

   task automatic test_protocol;
      checks++;
      if (proto_errs != 0) begin
         failures++; $display("FAIL strobe_protocol: got %0d violations expected 0", proto_errs);
      end
   endtask

   initial begin
      mem[int'(22'h000123)] = 8'h5A;
      mem[int'(22'h000111)] = 8'h3C;
      mem[int'(22'h000222)] = 8'h96;
      test_reset();
      test_priority();
      test_errors();
      test_reset_midop();
      test_refresh();
      test_refresh_urgent();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
